// File: rtl/twiddle_seq_ctrl_pkg.sv
// Shared types and helpers for the twiddle-weight sequencer (single-bin DFT path).
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    localparam logic CFG_SEL_RE = 1'b0;
    localparam logic CFG_SEL_IM = 1'b1;

    // Address width for a table of the given depth; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/twiddle_seq_ctrl_if.sv
// Sample-in / weighted-sample-out stream bundle of twiddle_seq_ctrl.
interface twiddle_seq_ctrl_if #(
    parameter int WIDTH    = 32,
    parameter int SAMPLE_W = 16
);
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_data;
    logic                m_valid;
    logic                m_ready;
    logic [SAMPLE_W-1:0] m_data;
    logic [WIDTH-1:0]    m_w_re;
    logic [WIDTH-1:0]    m_w_im;
    logic                m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_w_re, m_w_im, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_w_re, m_w_im, m_last
    );
endinterface

// File: rtl/twiddle_seq_ctrl_phase_acc.sv
// Mod-DEPTH phase accumulator: p advances by bin on every step and wraps below DEPTH.
module twiddle_phase_acc import fft_ctrl_pkg::*; #(
    parameter int DEPTH = 360,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    input  logic [AW-1:0] bin,
    output logic [AW-1:0] p
);
    localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] DEPTH_LO = AW'(DEPTH);

    logic [AW-1:0] r_p;
    logic [AW:0]   w_sum;
    logic [AW-1:0] w_next;

    // Sum kept one bit wider so the wrap compare sees the true value; p, bin < DEPTH
    // means a single subtraction always lands back in range.
    assign w_sum  = {1'b0, r_p} + {1'b0, bin};
    assign w_next = (w_sum >= DEPTH_X) ? (w_sum[AW-1:0] - DEPTH_LO) : w_sum[AW-1:0];

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p <= '0;
        end else if (clear) begin
            r_p <= '0;
        end else if (step) begin
            r_p <= w_next;
        end else begin
            r_p <= r_p;
        end
    end

    assign p = r_p;
endmodule

// File: rtl/twiddle_seq_ctrl.sv
// Twiddle-weight RAM controller: streams one DFT bin, pairing each sample with
// weight (bin*n) mod DEPTH; hands the RAM write port to cfg while idle.
module twiddle_seq_ctrl import fft_ctrl_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 360,
    parameter int SAMPLE_W = 16,
    parameter int AW       = addr_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        bin,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    twiddle_seq_ctrl_if.slave    strm,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 cfg_sel,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [WIDTH-1:0]     cfg_data,
    output logic [AW-1:0]        ram_addr,
    output logic                 ram_we_re,
    output logic                 ram_we_im,
    output logic [WIDTH-1:0]     ram_wdata,
    input  logic [WIDTH-1:0]     ram_re_rdata,
    input  logic [WIDTH-1:0]     ram_im_rdata
);
    localparam logic [1:0]    S_IDLE  = ST_IDLE;
    localparam logic [1:0]    S_RUN   = ST_RUN;
    localparam logic [1:0]    S_DRAIN = ST_DRAIN;
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] N_LAST  = AW'(DEPTH - 1);

    logic [1:0]          r_state;
    logic [AW-1:0]       r_bin;
    logic [AW-1:0]       r_n;
    logic                r_done;
    logic                r_err;
    logic                r_m_valid;
    logic                r_m_last;
    logic [SAMPLE_W-1:0] r_m_data;
    logic [WIDTH-1:0]    r_m_w_re;
    logic [WIDTH-1:0]    r_m_w_im;

    logic          w_idle, w_run;
    logic          w_bin_ok, w_clear;
    logic          w_cfg_ready, w_cfg_fire;
    logic          w_s_ready, w_s_fire, w_m_fire;
    logic [AW-1:0] w_p;

    assign w_idle      = (r_state == S_IDLE);
    assign w_run       = (r_state == S_RUN);
    assign w_bin_ok    = ({1'b0, bin} < DEPTH_X);
    assign w_clear     = w_idle && start && w_bin_ok;
    // start has priority over a reload in the same cycle
    assign w_cfg_ready = w_idle && !start;
    assign w_cfg_fire  = w_cfg_ready && cfg_valid;
    assign w_s_ready   = w_run && (!r_m_valid || strm.m_ready);
    assign w_s_fire    = w_s_ready && strm.s_valid;
    assign w_m_fire    = r_m_valid && strm.m_ready;

    twiddle_phase_acc #(.DEPTH(DEPTH), .AW(AW)) u_phase (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .step  (w_s_fire),
        .bin   (r_bin),
        .p     (w_p)
    );

    // Frame sequencing, sample index and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_n     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_bin_ok) begin
                        r_bin   <= bin;
                        r_n     <= '0;
                        r_state <= S_RUN;
                    end else if (start) begin
                        r_err <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_s_fire) begin
                        r_n <= r_n + AW'(1);
                        if (r_n == N_LAST) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (w_m_fire && r_m_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // One-deep output register; a capture in the same cycle as a handshake keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_m_w_re  <= '0;
            r_m_w_im  <= '0;
        end else if (w_s_fire) begin
            r_m_valid <= 1'b1;
            r_m_last  <= (r_n == N_LAST);
            r_m_data  <= strm.s_data;
            r_m_w_re  <= ram_re_rdata;
            r_m_w_im  <= ram_im_rdata;
        end else if (w_m_fire) begin
            r_m_valid <= 1'b0;
        end else begin
            r_m_valid <= r_m_valid;
        end
    end

    // RAM port steering: reload writes while idle, phase address while running.
    always_comb begin
        ram_addr  = '0;
        ram_we_re = 1'b0;
        ram_we_im = 1'b0;
        ram_wdata = cfg_data;
        if (w_cfg_fire) begin
            ram_addr  = cfg_addr;
            ram_we_re = (cfg_sel == CFG_SEL_RE);
            ram_we_im = (cfg_sel == CFG_SEL_IM);
        end else if (w_run) begin
            ram_addr = w_p;
        end else begin
            ram_addr = '0;
        end
    end

    assign busy         = !w_idle;
    assign done         = r_done;
    assign err          = r_err;
    assign cfg_ready    = w_cfg_ready;
    assign strm.s_ready = w_s_ready;
    assign strm.m_valid = r_m_valid;
    assign strm.m_last  = r_m_last;
    assign strm.m_data  = r_m_data;
    assign strm.m_w_re  = r_m_w_re;
    assign strm.m_w_im  = r_m_w_im;
endmodule
